// File: rtl/shift_issue_stage_pkg.sv
// Shared definitions for the shift issue stage: datapath width, op encoding and the
// arithmetic-right fill helper. The ALU decoder imports the same package for its op codes.
package shift_issue_stage_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      OpSrl = 2'b00,
      OpSll = 2'b01,
      OpSra = 2'b10,
      OpRor = 2'b11
   } shift_op_e;

   // Upper bits vacated by a logical right shift of amt; OR-ed in for negative SRA operands.
   function automatic logic [DATA_W-1:0] sra_fill_mask(input logic [4:0] amt);
      return ~({DATA_W{1'b1}} >> amt);
   endfunction

endpackage

// File: rtl/shift_issue_stage_barrel.sv
// 32-bit logarithmic barrel shifter, logical only (zero fill). left_i selects direction;
// left shifts reuse the right-shift network by bit-reversing the operand and the result.
module shift_issue_stage_barrel
   import shift_issue_stage_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   input  logic [4:0]        amt_i,
   input  logic              left_i,
   output logic [DATA_W-1:0] data_o
);

   logic [DATA_W-1:0] src;
   logic [DATA_W-1:0] acc;

   // Reverse for left shifts, run five conditional power-of-two stages, reverse back.
   always_comb begin
      src    = '0;
      acc    = '0;
      data_o = '0;
      for (int i = 0; i < DATA_W; i++) begin
         src[i] = left_i ? data_i[DATA_W-1-i] : data_i[i];
      end
      acc = src;
      for (int k = 0; k < 5; k++) begin
         if (amt_i[k]) acc = acc >> (1 << k);
      end
      for (int i = 0; i < DATA_W; i++) begin
         data_o[i] = left_i ? acc[DATA_W-1-i] : acc[i];
      end
   end

endmodule

// File: rtl/shift_issue_stage.sv
// Two-stage valid/ready shift issue stage. S1 registers the request, the shift is evaluated
// between S1 and S2, S2 registers the result for the writeback mux.
// Optional build macro SHIFT_ROTATE_EN: op 11 becomes rotate-right; otherwise op 11 yields
// a zero result flagged with out_err_o.
module shift_issue_stage
   import shift_issue_stage_pkg::*;
#(
   parameter int unsigned TAG_WIDTH    = 4,
   parameter bit          ZERO_ON_IDLE = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DATA_W-1:0]    in_d_i,
   input  logic [DATA_W-1:0]    in_s_i,
   input  logic [1:0]           in_op_i,
   input  logic [TAG_WIDTH-1:0] in_tag_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DATA_W-1:0]    out_y_o,
   output logic [TAG_WIDTH-1:0] out_tag_o,
   output logic                 out_err_o
);

   // Stage 1: raw request.
   logic                 s1_v_q, s1_v_d;
   logic [DATA_W-1:0]    s1_d_q, s1_d_d;
   logic [DATA_W-1:0]    s1_s_q, s1_s_d;
   shift_op_e            s1_op_q, s1_op_d;
   logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;

   // Stage 2: finished result.
   logic                 s2_v_q, s2_v_d;
   logic [DATA_W-1:0]    s2_y_q, s2_y_d;
   logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;
   logic                 s2_err_q, s2_err_d;

   logic adv1, adv2;

   logic [4:0]        s1_e;
   logic              s1_big;
   logic              s1_sign;
   logic [DATA_W-1:0] sh_y;
   logic [DATA_W-1:0] res_y;
   logic              res_err;

   assign adv2       = ~s2_v_q | out_ready_i;
   assign adv1       = ~s1_v_q | adv2;
   assign in_ready_o = adv1 & ~rst_i;

   assign s1_e    = s1_s_q[4:0];
   assign s1_big  = |s1_s_q[DATA_W-1:5];
   assign s1_sign = s1_d_q[DATA_W-1];

   // Right shift for everything except SLL; rotate reuses this as its right half.
   shift_issue_stage_barrel u_shift_main (
      .data_i (s1_d_q),
      .amt_i  (s1_e),
      .left_i (s1_op_q == OpSll),
      .data_o (sh_y)
   );

`ifdef SHIFT_ROTATE_EN
   logic [4:0]        rot_amt;
   logic [DATA_W-1:0] rot_y;

   // Left by 32-E; E=0 wraps to 0 so the OR below still returns D unchanged.
   assign rot_amt = 5'd0 - s1_e;

   shift_issue_stage_barrel u_shift_rot (
      .data_i (s1_d_q),
      .amt_i  (rot_amt),
      .left_i (1'b1),
      .data_o (rot_y)
   );
`endif

   // Saturation of out-of-range amounts and SRA sign fill around the bare shifter.
   always_comb begin
      res_y   = sh_y;
      res_err = 1'b0;
      unique case (s1_op_q)
         OpSrl, OpSll: begin
            if (s1_big) res_y = '0;
         end
         OpSra: begin
            if (s1_big) res_y = {DATA_W{s1_sign}};
            else        res_y = sh_y | (s1_sign ? sra_fill_mask(s1_e) : '0);
         end
         OpRor: begin
`ifdef SHIFT_ROTATE_EN
            res_y = sh_y | rot_y;
`else
            res_y   = '0;
            res_err = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // Next-state for both stages: each stage loads only when the stage ahead frees up.
   always_comb begin
      s1_v_d   = s1_v_q;
      s1_d_d   = s1_d_q;
      s1_s_d   = s1_s_q;
      s1_op_d  = s1_op_q;
      s1_tag_d = s1_tag_q;
      s2_v_d   = s2_v_q;
      s2_y_d   = s2_y_q;
      s2_tag_d = s2_tag_q;
      s2_err_d = s2_err_q;
      if (adv1) begin
         s1_v_d = in_valid_i;
         if (in_valid_i) begin
            s1_d_d   = in_d_i;
            s1_s_d   = in_s_i;
            s1_op_d  = shift_op_e'(in_op_i);
            s1_tag_d = in_tag_i;
         end
      end
      if (adv2) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_y_d   = res_y;
            s2_tag_d = s1_tag_q;
            s2_err_d = res_err;
         end
      end
   end

   // Pipeline registers; reset discards any in-flight request in both stages.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_v_q   <= 1'b0;
         s1_d_q   <= '0;
         s1_s_q   <= '0;
         s1_op_q  <= OpSrl;
         s1_tag_q <= '0;
         s2_v_q   <= 1'b0;
         s2_y_q   <= '0;
         s2_tag_q <= '0;
         s2_err_q <= 1'b0;
      end else begin
         s1_v_q   <= s1_v_d;
         s1_d_q   <= s1_d_d;
         s1_s_q   <= s1_s_d;
         s1_op_q  <= s1_op_d;
         s1_tag_q <= s1_tag_d;
         s2_v_q   <= s2_v_d;
         s2_y_q   <= s2_y_d;
         s2_tag_q <= s2_tag_d;
         s2_err_q <= s2_err_d;
      end
   end

   // Output drive; idle data is zeroed or held depending on ZERO_ON_IDLE.
   always_comb begin
      out_valid_o = s2_v_q;
      out_err_o   = s2_v_q & s2_err_q;
      if (ZERO_ON_IDLE && !s2_v_q) begin
         out_y_o   = '0;
         out_tag_o = '0;
      end else begin
         out_y_o   = s2_y_q;
         out_tag_o = s2_tag_q;
      end
   end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: directed scenarios plus randomized traffic,
// checked every cycle against an in-order queue model of the pipeline.
module tb_shift_issue_stage;

   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_d;
   logic [31:0]   in_s;
   logic [1:0]    in_op;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_y;
   logic [TW-1:0] out_tag;
   logic          out_err;

   always #5 clk = ~clk;

   shift_issue_stage #(
      .TAG_WIDTH    (TW),
      .ZERO_ON_IDLE (1'b1)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_d_i      (in_d),
      .in_s_i      (in_s),
      .in_op_i     (in_op),
      .in_tag_i    (in_tag),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_y_o     (out_y),
      .out_tag_o   (out_tag),
      .out_err_o   (out_err)
   );

   typedef struct {
      logic [31:0]   y;
      logic [TW-1:0] tag;
      logic          err;
      int            pcyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_y(input logic [31:0] d, input logic [31:0] s,
                                         input logic [1:0] op);
      logic [63:0] t;
      case (op)
         2'b00:   return (s >= 32) ? 32'd0 : d >> s;
         2'b01:   return (s >= 32) ? 32'd0 : d << s;
         2'b10:   return (s >= 32) ? {32{d[31]}} : 32'($signed(d) >>> s);
         default: begin
`ifdef SHIFT_ROTATE_EN
            t = {d, d} >> (s % 32);
            return t[31:0];
`else
            t = '0;
            return t[31:0];
`endif
         end
      endcase
   endfunction

   function automatic logic ref_err(input logic [1:0] op);
`ifdef SHIFT_ROTATE_EN
      return 1'b0;
`else
      return op == 2'b11;
`endif
   endfunction

   // One clock: drive, check outputs against the model, clock, update the model.
   task automatic cycle(input logic v, input logic [31:0] d, input logic [31:0] s,
                        input logic [1:0] op, input logic [TW-1:0] tg, input logic ordy,
                        input logic r, output logic accepted);
      logic exp_valid, exp_rdy, fire_in, fire_out;
      exp_t e;
      rst = r; in_valid = v; in_d = d; in_s = s; in_op = op; in_tag = tg; out_ready = ordy;
      @(negedge clk);
      exp_valid = (q.size() > 0) && (cyc - q[0].pcyc >= 1);
      exp_rdy   = !r && !(q.size() == 2 && !ordy);
      check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
      check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
         check_eq("out_y", out_y, q[0].y);
         check_eq("out_tag", 32'(out_tag), 32'(q[0].tag));
         check_eq("out_err", 32'(out_err), 32'(q[0].err));
      end else begin
         check_eq("idle_y", out_y, 32'd0);
         check_eq("idle_tag", 32'(out_tag), 32'd0);
         check_eq("idle_err", 32'(out_err), 32'd0);
      end
      fire_in  = v && exp_rdy;
      fire_out = exp_valid && ordy && !r;
      accepted = fire_in;
      @(posedge clk);
      cyc++;
      if (r) begin
         q.delete();
      end else begin
         if (fire_out) void'(q.pop_front());
         if (fire_in) begin
            e.y = ref_y(d, s, op); e.tag = tg; e.err = ref_err(op); e.pcyc = cyc;
            q.push_back(e);
         end
      end
      #1;
   endtask

   task automatic idle(input int n, input logic ordy);
      logic a;
      for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 2'b00, '0, ordy, 1'b0, a);
   endtask

   logic          acc;
   logic [31:0]   rd[3];
   logic [31:0]   rs[3];
   logic [1:0]    rop[3];
   int            idx;
   int            guard;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_d = '0; in_s = '0; in_op = '0; in_tag = '0;
      out_ready = 1'b0;
      // Reset, then check idle state.
      cycle(1'b0, 32'd0, 32'd0, 2'b00, '0, 1'b1, 1'b1, acc);
      cycle(1'b0, 32'd0, 32'd0, 2'b00, '0, 1'b1, 1'b1, acc);
      idle(2, 1'b1);

      // Basic shifts with tag echo.
      cycle(1'b1, 32'd50, 32'd1, 2'b01, 4'd3, 1'b1, 1'b0, acc);
      cycle(1'b1, 32'd500, 32'd2, 2'b00, 4'd5, 1'b1, 1'b0, acc);
      idle(3, 1'b1);

      // Sign fill and saturation.
      cycle(1'b1, 32'h8000_0000, 32'd4, 2'b10, 4'd1, 1'b1, 1'b0, acc);
      cycle(1'b1, 32'h8000_0000, 32'd45, 2'b10, 4'd2, 1'b1, 1'b0, acc);
      cycle(1'b1, 32'd2, 32'd45, 2'b01, 4'd4, 1'b1, 1'b0, acc);
      cycle(1'b1, 32'h1234_5678, 32'd0, 2'b10, 4'd6, 1'b1, 1'b0, acc);
      cycle(1'b1, 32'h7000_0000, 32'd31, 2'b10, 4'd7, 1'b1, 1'b0, acc);
      idle(3, 1'b1);

      // Back-to-back full throughput.
      for (int i = 0; i < 4; i++)
         cycle(1'b1, $urandom, 32'($urandom_range(0, 31)), 2'($urandom_range(0, 2)),
               TW'(i + 8), 1'b1, 1'b0, acc);
      idle(3, 1'b1);

      // Backpressure: three requests offered while the consumer stalls for five cycles.
      for (int i = 0; i < 3; i++) begin
         rd[i] = $urandom; rs[i] = 32'($urandom_range(0, 40)); rop[i] = 2'($urandom_range(0, 2));
      end
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         if (idx < 3) begin
            cycle(1'b1, rd[idx], rs[idx], rop[idx], TW'(idx), 1'b0, 1'b0, acc);
            if (acc) idx++;
         end else begin
            idle(1, 1'b0);
         end
      end
      check_eq("bp_accepts", 32'(idx), 32'd2);
      guard = 0;
      while (idx < 3 && guard < 20) begin
         cycle(1'b1, rd[idx], rs[idx], rop[idx], TW'(idx), 1'b1, 1'b0, acc);
         if (acc) idx++;
         guard++;
      end
      check_eq("bp_third_accept", 32'(idx), 32'd3);
      idle(4, 1'b1);

      // Reset with both stages full.
      cycle(1'b1, 32'hAAAA_5555, 32'd3, 2'b00, 4'd9, 1'b0, 1'b0, acc);
      cycle(1'b1, 32'h5555_AAAA, 32'd7, 2'b01, 4'd10, 1'b0, 1'b0, acc);
      cycle(1'b0, 32'd0, 32'd0, 2'b00, '0, 1'b0, 1'b1, acc);
      idle(1, 1'b1);
      cycle(1'b1, 32'd50, 32'd1, 2'b01, 4'd11, 1'b1, 1'b0, acc);
      idle(3, 1'b1);

      // Reserved/rotate op.
      cycle(1'b1, 32'd1, 32'd1, 2'b11, 4'd12, 1'b1, 1'b0, acc);
      cycle(1'b1, 32'hDEAD_BEEF, 32'd36, 2'b11, 4'd13, 1'b1, 1'b0, acc);
      cycle(1'b1, 32'hDEAD_BEEF, 32'd0, 2'b11, 4'd14, 1'b1, 1'b0, acc);
      idle(3, 1'b1);

      // Randomized traffic with random backpressure and rare resets.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] s;
         case ($urandom_range(0, 3))
            0:       s = 32'd0;
            1:       s = 32'($urandom_range(1, 31));
            2:       s = 32'd32;
            default: s = $urandom;
         endcase
         cycle($urandom_range(0, 9) < 7, $urandom, s, 2'($urandom_range(0, 3)),
               TW'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, acc);
      end
      idle(4, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
